// File: rtl/bp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : bp_pkg                                                  |
// | Shared types, counter encodings and helpers for the predictor.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package bp_pkg;

    localparam int c_hist_w_def = 14;

    typedef logic [1:0] cnt_t;

    localparam cnt_t c_snt = 2'd0;
    localparam cnt_t c_wnt = 2'd1;
    localparam cnt_t c_wt  = 2'd2;
    localparam cnt_t c_st  = 2'd3;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic cnt_t sat_next(input cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == c_st) ? c_st : cnt + 2'd1;
        end
        return (cnt == c_snt) ? c_snt : cnt - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pht_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pht_ram                                                 |
// | Counter storage: two async read ports, one sync write port.      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pht_ram
    import bp_pkg::*;
#(
    parameter int HIST_W = c_hist_w_def
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [HIST_W-1:0] i_wr_addr,
    input  cnt_t              i_wr_data,
    input  logic [HIST_W-1:0] i_lk_addr,
    output cnt_t              o_lk_data,
    input  logic [HIST_W-1:0] i_up_addr,
    output cnt_t              o_up_data
);

    cnt_t r_mem [2**HIST_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_lk_data = r_mem[i_lk_addr];
    assign o_up_data = r_mem[i_up_addr];

endmodule
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : gshare_pht                                              |
// | Gshare PHT: hashed lookup, pipelined training, init sweep.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module gshare_pht
    import bp_pkg::*;
#(
    parameter int HIST_W = c_hist_w_def,
    parameter int PC_W   = 32,
    parameter int PC_LSB = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HIST_W-1:0] ghr,
    input  logic              pred_req,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_index,
    input  logic              upd_en,
    input  logic [HIST_W-1:0] upd_index,
    input  logic              upd_taken,
    output logic              hist_wr_en,
    output logic              hist_wr_data,
    output logic              ready
);

    state_t            r_state;
    logic [HIST_W-1:0] r_init_idx;
    logic              r_u_valid;
    logic [HIST_W-1:0] r_u_index;
    logic              r_u_taken;

    logic [HIST_W-1:0] w_idx;
    logic              w_is_ready;
    logic              w_unused_pc;
    cnt_t              w_lk_cnt;
    cnt_t              w_u_cnt;
    cnt_t              w_u_next;
    logic              w_we;
    logic [HIST_W-1:0] w_wr_addr;
    cnt_t              w_wr_data;

    assign w_idx       = pred_pc[PC_LSB +: HIST_W] ^ ghr;
    assign w_unused_pc = ^pred_pc;
    assign w_is_ready  = (r_state == READY);
    assign w_u_next    = sat_next(w_u_cnt, r_u_taken);

    assign hist_wr_en   = r_u_valid;
    assign hist_wr_data = r_u_taken;

    // The sweep owns the write port until READY; afterwards the update stage does.
    always_comb begin
        w_we      = 1'b0;
        w_wr_addr = r_init_idx;
        w_wr_data = c_wnt;
        if (!reset) begin
            if (r_state == INIT) begin
                w_we = 1'b1;
            end else if (r_u_valid) begin
                w_we      = 1'b1;
                w_wr_addr = r_u_index;
                w_wr_data = w_u_next;
            end
        end
    end

    pht_ram #(
        .HIST_W (HIST_W)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_lk_addr (w_idx),
        .o_lk_data (w_lk_cnt),
        .i_up_addr (r_u_index),
        .o_up_data (w_u_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_idx <= '0;
            r_u_valid  <= 1'b0;
            r_u_index  <= '0;
            r_u_taken  <= 1'b0;
            ready      <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            if (r_state == INIT) begin
                r_init_idx <= r_init_idx + {{(HIST_W-1){1'b0}}, 1'b1};
                if (&r_init_idx) begin
                    r_state <= READY;
                    ready   <= 1'b1;
                end
            end

            r_u_valid <= upd_en && w_is_ready;
            if (upd_en && w_is_ready) begin
                r_u_index <= upd_index;
                r_u_taken <= upd_taken;
            end

            pred_valid <= pred_req && w_is_ready;
            if (pred_req && w_is_ready) begin
                pred_index <= w_idx;
                // Write-first bypass of the counter being written this edge.
                pred_taken <= (r_u_valid && (r_u_index == w_idx)) ? w_u_next[1] : w_lk_cnt[1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_pht.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_gshare_pht                                           |
// | Self-checking bench for gshare_pht against a counter-array model.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_gshare_pht;

    localparam int HIST_W = 14;
    localparam int PC_W   = 32;
    localparam int PC_LSB = 2;
    localparam int DEPTH  = 1 << HIST_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [HIST_W-1:0] ghr;
    logic              pred_req;
    logic [PC_W-1:0]   pred_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_index;
    logic              upd_en;
    logic [HIST_W-1:0] upd_index;
    logic              upd_taken;
    logic              hist_wr_en;
    logic              hist_wr_data;
    logic              ready;

    always #5 clk = ~clk;

    gshare_pht #(
        .HIST_W (HIST_W),
        .PC_W   (PC_W),
        .PC_LSB (PC_LSB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ghr          (ghr),
        .pred_req     (pred_req),
        .pred_pc      (pred_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_index   (pred_index),
        .upd_en       (upd_en),
        .upd_index    (upd_index),
        .upd_taken    (upd_taken),
        .hist_wr_en   (hist_wr_en),
        .hist_wr_data (hist_wr_data),
        .ready        (ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: counter values as plain integers plus the cycles left in the sweep.
    int model_cnt [DEPTH];
    int init_left;
    bit pend_v;
    int pend_idx;
    bit pend_t;
    bit e_valid, e_taken, e_hwe, e_hwd, e_ready;
    int e_index;

    int pool [4] = '{32'h28b9, 32'h0001, 32'h1234, 32'h3fff};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int hash_of(input logic [31:0] pc, input int g);
        return int'((pc >> PC_LSB) & 32'(DEPTH - 1)) ^ g;
    endfunction

    task automatic drive(input bit req, input logic [31:0] pc, input int g,
                         input bit ue, input int ui, input bit ut);
        pred_req  = req;
        pred_pc   = pc;
        ghr       = HIST_W'(g);
        upd_en    = ue;
        upd_index = HIST_W'(ui);
        upd_taken = ut;
    endtask

    task automatic tick();
        if (reset) begin
            init_left = DEPTH;
            pend_v    = 0;
            e_valid   = 0;
            e_taken   = 0;
            e_index   = 0;
            e_hwe     = 0;
            e_hwd     = 0;
            foreach (model_cnt[i]) model_cnt[i] = 1;
        end else if (init_left > 0) begin
            init_left--;
            e_valid = 0;
            e_hwe   = 0;
        end else begin
            // An update becomes visible to lookups one cycle after it is presented.
            if (pend_v) begin
                if (pend_t) model_cnt[pend_idx] = (model_cnt[pend_idx] + 1 > 3) ? 3 : model_cnt[pend_idx] + 1;
                else        model_cnt[pend_idx] = (model_cnt[pend_idx] - 1 < 0) ? 0 : model_cnt[pend_idx] - 1;
            end
            e_valid = pred_req;
            if (pred_req) begin
                e_index = hash_of(pred_pc, int'(ghr));
                e_taken = (model_cnt[e_index] >= 2);
            end
            e_hwe = upd_en;
            if (upd_en) e_hwd = upd_taken;
            pend_v   = upd_en;
            pend_idx = int'(upd_index);
            pend_t   = upd_taken;
        end
        e_ready = !reset && (init_left == 0);
        @(posedge clk);
        #1;
        check_eq("ready",        32'(ready),        32'(e_ready));
        check_eq("pred_valid",   32'(pred_valid),   32'(e_valid));
        check_eq("pred_taken",   32'(pred_taken),   32'(e_taken));
        check_eq("pred_index",   32'(pred_index),   32'(e_index));
        check_eq("hist_wr_en",   32'(hist_wr_en),   32'(e_hwe));
        check_eq("hist_wr_data", 32'(hist_wr_data), 32'(e_hwd));
    endtask

    task automatic train(input int idx, input bit t, input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 1, idx, t);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic lookup_28b9();
        drive(1, 32'h0000_1000, 32'h2cb9, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_eq("reset_ready", 32'(ready), 32'd0);

        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick();
        check_eq("init_ready_at_depth", 32'(ready), 32'd1);
        tick();
        check_eq("first_pred_valid", 32'(pred_valid), 32'd1);

        lookup_28b9();
        check_eq("hash_index", 32'(pred_index), 32'h28b9);
        check_eq("hash_taken", 32'(pred_taken), 32'd0);

        train(32'h28b9, 1'b1, 3);
        lookup_28b9();
        check_eq("train_up_taken", 32'(pred_taken), 32'd1);

        train(32'h28b9, 1'b0, 4);
        lookup_28b9();
        check_eq("train_down_taken", 32'(pred_taken), 32'd0);

        train(32'h28b9, 1'b1, 1);
        drive(0, 0, 0, 1, 32'h28b9, 1);
        tick();
        lookup_28b9();
        check_eq("bypass_taken", 32'(pred_taken), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            int          tgt;
            pc  = $urandom;
            tgt = pool[$urandom_range(0, 3)];
            drive($urandom_range(0, 1) == 1, pc, hash_of(pc, tgt),
                  $urandom_range(0, 2) != 0, pool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1);
            tick();
        end

        train(32'h28b9, 1'b1, 3);
        lookup_28b9();
        check_eq("pre_reset_taken", 32'(pred_taken), 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick();
        check_eq("reinit_ready", 32'(ready), 32'd1);
        lookup_28b9();
        check_eq("reinit_taken", 32'(pred_taken), 32'd0);
        check_eq("reinit_index", 32'(pred_index), 32'h28b9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Gshare pattern history table that sits directly downstream of sh_reg.
- Hashes the 14-bit global history (sh_reg rd_data) with the branch PC and indexes 2^HIST_W two-bit saturating counters. It returns a registered taken/not-taken prediction.
- On branch resolution it trains the addressed counter. It also emits the resolved outcome as a one-cycle history write (wr_en/wr_data) back to sh_reg.
- A power-up sweep initialises the table after every reset.

Parameters:
HIST_W, 14, global history width; table depth = 2^HIST_W
PC_W, 32, branch PC width
PC_LSB, 2, lowest PC bit used in the hash (word-aligned instructions)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ghr  in  HIST_W  global history from sh_reg rd_data
pred_req  in  1  lookup request, one per cycle
pred_pc  in  PC_W  PC of branch being predicted
pred_valid  out  1  prediction valid (one cycle after pred_req)
pred_taken  out  1  predicted direction (counter MSB)
pred_index  out  HIST_W  index used; carried with branch, returned on update
upd_en  in  1  resolution update strobe
upd_index  in  HIST_W  index returned from pred_index
upd_taken  in  1  resolved direction
hist_wr_en  out  1  to sh_reg wr_en
hist_wr_data  out  1  to sh_reg wr_data
ready  out  1  table initialised; lookups/updates accepted

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values: ready=0, pred_valid=0, pred_taken=0, pred_index=0, hist_wr_en=0, hist_wr_data=0. The update stage is cleared, state=INIT, init_idx=0.
- FSM state INIT:
  - Each cycle writes 2'b01 (weakly not-taken) to entry init_idx, then init_idx++.
  - The write at init_idx=2^HIST_W-1 moves the FSM to READY on the next edge.
  - ready=1 from the first READY cycle. Init takes exactly 2^HIST_W cycles after reset deasserts.
- FSM state READY: holds until reset. Reset in any state, including mid-sweep, restarts INIT at index 0.
- Requests during INIT: pred_req and upd_en are ignored. pred_valid stays 0, no table write, no hist_wr_en.
- Hash: idx = pred_pc[PC_LSB+HIST_W-1:PC_LSB] XOR ghr.
- Lookup:
  - pred_req in cycle t makes pred_valid=1 in cycle t+1, with pred_taken=counter[1] and pred_index=idx.
  - pred_valid is 0 in any cycle following a cycle with no pred_req. pred_taken/pred_index hold their last value.
- Update, cycle t: upd_en is registered into update stage U (index, taken).
- Update, cycle t+1:
  - U reads the counter and computes the saturating result: taken gives min(c+1,3), not-taken gives max(c-1,0).
  - The result is written on edge t+2.
  - hist_wr_en=1 and hist_wr_data=upd_taken for exactly this one cycle.
- Bypass: a lookup in cycle t+1 whose idx equals U.index sees the new counter value (write-first).
- Back-to-back updates (upd_en in consecutive cycles, any indices) are fully pipelined, one per cycle. A same-index pair needs no forwarding because the write lands before the next U read.
- Simultaneous lookup and update to different indices are independent.
- No arithmetic wraps; counters saturate at 0 and 3.

Decomposition:
- Package bp_pkg:
  - HIST_W default
  - counter typedef (2-bit)
  - constants SNT=0, WNT=1, WT=2, ST=3
  - FSM state enum {INIT, READY}
  - function sat_next(cnt, taken)
- Sub-module pht_ram: 2^HIST_W x 2 register array.
  - Two asynchronous read ports (lookup, update).
  - One synchronous write port, muxed between the init sweep and the update stage.
- Hash, FSM, bypass and the history-write output stay in gshare_pht.

Test Plan:
1. Init: reset 2 cycles, release, with pred_req=1 every cycle -> pred_valid=0 and ready=0 for 16384 cycles. ready=1 at cycle 16384; first valid prediction the cycle after.
2. Lookup: pred_pc=0x00001000, ghr=0x2cb9 -> next cycle pred_valid=1, pred_index=0x28b9 (0x0400^0x2cb9), pred_taken=0.
3. Train up: upd_en with upd_index=0x28b9, taken=1 on three consecutive cycles -> hist_wr_en pulses 3 cycles with data 1. Counter goes 1->2->3->3; lookup afterwards gives pred_taken=1.
4. Train down: four not-taken updates to 0x28b9 starting from 3 -> counter goes 2,1,0,0; lookup gives pred_taken=0; hist_wr_data=0 on each pulse.
5. Bypass: counter=1; upd_en taken=1 at cycle t; pred_req with the same idx at t+1 -> pred_taken=1 at t+2.
6. Reset mid-init: assert reset at init_idx=100, release -> ready stays 0 for a full 16384 cycles. Entries previously trained to 3 read back as 1 (pred_taken=0).
